// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one spi_controller engine among NUM_REQ requesters.
// It latches the winning command, sequences the engine's start/busy handshake and returns the masked response.
module spi_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int ID_W          = 2,
    parameter int START_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*64-1:0]  req_command,
    input  logic [NUM_REQ*3-1:0]   req_len,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   resp_valid,
    output logic [ID_W-1:0]        resp_id,
    output logic [63:0]            resp_data,
    output logic                   resp_err,
    output logic [63:0]            spi_command,
    output logic [2:0]             spi_len,
    output logic                   spi_start,
    input  logic                   spi_busy,
    input  logic [63:0]            spi_response
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

    localparam logic [7:0]      TIMEOUT_C = 8'(START_TIMEOUT);
    localparam logic [ID_W-1:0] LAST_ID_C = ID_W'(NUM_REQ - 1);

    // Keeps response bytes 0..len (MSB first) and clears the untransferred tail.
    function automatic logic [63:0] mask_resp(input logic [63:0] data, input logic [2:0] len);
        logic [5:0] sh;
        sh = 6'd56 - {len, 3'b000};
        return data & ({64{1'b1}} << sh);
    endfunction

    state_t                state_r, state_nxt_s;
    logic [ID_W-1:0]       last_r, last_nxt_s;
    logic [ID_W-1:0]       cur_id_r, cur_id_nxt_s;
    logic [7:0]            cnt_r, cnt_nxt_s;
    logic [NUM_REQ-1:0]    ack_r, ack_nxt_s;
    logic                  resp_valid_r, resp_valid_nxt_s;
    logic [ID_W-1:0]       resp_id_r, resp_id_nxt_s;
    logic [63:0]           resp_data_r, resp_data_nxt_s;
    logic                  resp_err_r, resp_err_nxt_s;
    logic [63:0]           spi_command_r, spi_command_nxt_s;
    logic [2:0]            spi_len_r, spi_len_nxt_s;
    logic                  spi_start_r, spi_start_nxt_s;

    logic                  win_found_s;
    logic [ID_W-1:0]       win_id_s;
    logic [63:0]           win_cmd_s;
    logic [2:0]            win_len_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [ID_W-1:0] idx_v;
        idx_v       = last_r;
        win_found_s = 1'b0;
        win_id_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (idx_v == LAST_ID_C) begin
                idx_v = '0;
            end else begin
                idx_v = idx_v + 1'b1;
            end
            if (!win_found_s && req[idx_v]) begin
                win_found_s = 1'b1;
                win_id_s    = idx_v;
            end else begin
                win_id_s    = win_id_s;
            end
        end
    end

    // Selects the winner's command and length from the packed request buses.
    always_comb begin
        win_cmd_s = 64'd0;
        win_len_s = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id_s == ID_W'(i)) begin
                win_cmd_s = req_command[64*i +: 64];
                win_len_s = req_len[3*i +: 3];
            end else begin
                win_cmd_s = win_cmd_s;
            end
        end
    end

    // Next-state and next-output logic; pulses default low, held values default to hold.
    always_comb begin
        state_nxt_s       = state_r;
        last_nxt_s        = last_r;
        cur_id_nxt_s      = cur_id_r;
        cnt_nxt_s         = cnt_r;
        ack_nxt_s         = '0;
        resp_valid_nxt_s  = 1'b0;
        resp_id_nxt_s     = resp_id_r;
        resp_data_nxt_s   = resp_data_r;
        resp_err_nxt_s    = resp_err_r;
        spi_command_nxt_s = spi_command_r;
        spi_len_nxt_s     = spi_len_r;
        spi_start_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    spi_command_nxt_s = win_cmd_s;
                    spi_len_nxt_s     = win_len_s;
                    cur_id_nxt_s      = win_id_s;
                    last_nxt_s        = win_id_s;
                    ack_nxt_s         = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id_s;
                    spi_start_nxt_s   = 1'b1;
                    state_nxt_s       = ST_START;
                end else begin
                    state_nxt_s       = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_nxt_s   = 8'd0;
                state_nxt_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (cnt_r + 8'd1 == TIMEOUT_C) begin
                    // Engine never acknowledged the start: report an error with empty data.
                    resp_valid_nxt_s = 1'b1;
                    resp_id_nxt_s    = cur_id_r;
                    resp_data_nxt_s  = 64'd0;
                    resp_err_nxt_s   = 1'b1;
                    state_nxt_s      = ST_RESPOND;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!spi_busy) begin
                    resp_valid_nxt_s = 1'b1;
                    resp_id_nxt_s    = cur_id_r;
                    resp_data_nxt_s  = mask_resp(spi_response, spi_len_r);
                    resp_err_nxt_s   = 1'b0;
                    state_nxt_s      = ST_RESPOND;
                end else begin
                    state_nxt_s      = ST_WAIT_DONE;
                end
            end
            ST_RESPOND: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            last_r        <= LAST_ID_C;
            cur_id_r      <= '0;
            cnt_r         <= 8'd0;
            ack_r         <= '0;
            resp_valid_r  <= 1'b0;
            resp_id_r     <= '0;
            resp_data_r   <= 64'd0;
            resp_err_r    <= 1'b0;
            spi_command_r <= 64'd0;
            spi_len_r     <= 3'd0;
            spi_start_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            last_r        <= last_nxt_s;
            cur_id_r      <= cur_id_nxt_s;
            cnt_r         <= cnt_nxt_s;
            ack_r         <= ack_nxt_s;
            resp_valid_r  <= resp_valid_nxt_s;
            resp_id_r     <= resp_id_nxt_s;
            resp_data_r   <= resp_data_nxt_s;
            resp_err_r    <= resp_err_nxt_s;
            spi_command_r <= spi_command_nxt_s;
            spi_len_r     <= spi_len_nxt_s;
            spi_start_r   <= spi_start_nxt_s;
        end
    end

    assign ack         = ack_r;
    assign resp_valid  = resp_valid_r;
    assign resp_id     = resp_id_r;
    assign resp_data   = resp_data_r;
    assign resp_err    = resp_err_r;
    assign spi_command = spi_command_r;
    assign spi_len     = spi_len_r;
    assign spi_start   = spi_start_r;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: stimulus queues expected grants/starts/responses,
// a negedge monitor pops and compares whenever the DUT presents ack, spi_start or resp_valid.
module tb_spi_arbiter;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    req = 3'b000;
    logic [63:0]   cmd [3];
    logic [2:0]    len [3];
    logic [191:0]  req_command;
    logic [8:0]    req_len;
    logic [2:0]    ack;
    logic          resp_valid;
    logic [1:0]    resp_id;
    logic [63:0]   resp_data;
    logic          resp_err;
    logic [63:0]   spi_command;
    logic [2:0]    spi_len;
    logic          spi_start;
    logic          spi_busy;
    logic [63:0]   spi_response;

    logic [63:0]   eng_resp = 64'd0;
    logic          eng_busy_mode = 1'b1;
    logic [7:0]    eng_cnt = 8'd0;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
        logic        err;
        int          lat;
    } resp_t;

    resp_t         exp_resp_q [$];
    logic [2:0]    exp_ack_q [$];
    logic [66:0]   exp_start_q [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;

    assign req_command  = {cmd[2], cmd[1], cmd[0]};
    assign req_len      = {len[2], len[1], len[0]};
    assign spi_busy     = (eng_cnt != 8'd0);
    assign spi_response = eng_resp;

    spi_arbiter #(.NUM_REQ(3), .ID_W(2), .START_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_command  (req_command),
        .req_len      (req_len),
        .ack          (ack),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .spi_command  (spi_command),
        .spi_len      (spi_len),
        .spi_start    (spi_start),
        .spi_busy     (spi_busy),
        .spi_response (spi_response)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: busy for 16 cycles after each start, unless it is told to stay silent.
    always @(posedge clk) begin
        if (spi_start && eng_busy_mode) eng_cnt <= 8'd16;
        else if (eng_cnt != 8'd0)       eng_cnt <= eng_cnt - 8'd1;
        else                            eng_cnt <= eng_cnt;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ack"},         64'(ack),         64'd0);
        check({pfx, "_resp_valid"},  64'(resp_valid),  64'd0);
        check({pfx, "_resp_id"},     64'(resp_id),     64'd0);
        check({pfx, "_resp_data"},   resp_data,        64'd0);
        check({pfx, "_resp_err"},    64'(resp_err),    64'd0);
        check({pfx, "_spi_command"}, spi_command,      64'd0);
        check({pfx, "_spi_len"},     64'(spi_len),     64'd0);
        check({pfx, "_spi_start"},   64'(spi_start),   64'd0);
    endtask

    task automatic expect_txn(input int id, input logic [63:0] data, input logic err, input int lat);
        resp_t r;
        exp_ack_q.push_back(3'b001 << id);
        exp_start_q.push_back({cmd[id], len[id]});
        r.id   = 2'(id);
        r.data = data;
        r.err  = err;
        r.lat  = lat;
        exp_resp_q.push_back(r);
    endtask

    task automatic wait_ack(input logic drop);
        int n;
        n = 0;
        @(negedge clk);
        while (ack == 3'b000 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (ack == 3'b000) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got no ack required one within 60 cycles");
        end else if (drop) begin
            req = req & ~ack;
        end else begin
            req = req;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_resp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_resp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: got %0d pending responses required 0", exp_resp_q.size());
            exp_resp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares every DUT event against the head of its scoreboard queue.
    initial begin
        logic [66:0] e;
        resp_t       r;
        forever begin
            @(negedge clk);
            if (ack != 3'b000) begin
                if (exp_ack_q.size() == 0) check("ack_unexpected", 64'(ack), 64'd0);
                else                       check("ack", 64'(ack), 64'(exp_ack_q.pop_front()));
            end
            if (spi_start) begin
                start_cyc = cyc;
                if (exp_start_q.size() == 0) begin
                    check("start_unexpected", 64'(spi_start), 64'd0);
                end else begin
                    e = exp_start_q.pop_front();
                    check("start_cmd", spi_command, e[66:3]);
                    check("start_len", 64'(spi_len), 64'(e[2:0]));
                end
            end
            if (resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    r = exp_resp_q.pop_front();
                    check("resp_id",   64'(resp_id),  64'(r.id));
                    check("resp_data", resp_data,     r.data);
                    check("resp_err",  64'(resp_err), 64'(r.err));
                    check("resp_lat",  64'(cyc - start_cyc), 64'(r.lat));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        cmd[0] = 64'hA500_0000_0000_0000;
        cmd[1] = 64'h1111_2222_3333_4444;
        cmd[2] = 64'h5555_6666_7777_8888;
        len[0] = 3'd0;
        len[1] = 3'd1;
        len[2] = 3'd5;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single request, len 0.
        eng_resp = 64'h3C12_3456_789A_BCDE;
        expect_txn(0, 64'h3C00_0000_0000_0000, 1'b0, 18);
        req = 3'b001;
        wait_ack(1'b1);
        wait_done();

        // Round-robin with all requesters held high, starting from a fresh pointer.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        eng_resp = 64'h0123_4567_89AB_CDEF;
        len[0]   = 3'd7;
        expect_txn(0, 64'h0123_4567_89AB_CDEF, 1'b0, 18);
        expect_txn(1, 64'h0123_0000_0000_0000, 1'b0, 18);
        expect_txn(2, 64'h0123_4567_89AB_0000, 1'b0, 18);
        expect_txn(0, 64'h0123_4567_89AB_CDEF, 1'b0, 18);
        req = 3'b111;
        repeat (4) wait_ack(1'b0);
        req = 3'b000;
        wait_done();

        // Fairness after skip: last grant was 0, so 2 wins over 0.
        expect_txn(2, 64'h0123_4567_89AB_0000, 1'b0, 18);
        expect_txn(0, 64'h0123_4567_89AB_CDEF, 1'b0, 18);
        req = 3'b101;
        wait_ack(1'b1);
        wait_ack(1'b1);
        wait_done();

        // Masking at len 3 and len 7.
        eng_resp = 64'hFFFF_FFFF_FFFF_FFFF;
        len[0]   = 3'd3;
        expect_txn(0, 64'hFFFF_FFFF_0000_0000, 1'b0, 18);
        req = 3'b001;
        wait_ack(1'b1);
        wait_done();
        len[0] = 3'd7;
        expect_txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 18);
        req = 3'b001;
        wait_ack(1'b1);
        wait_done();

        // Start timeout, then a normal transfer.
        eng_busy_mode = 1'b0;
        expect_txn(0, 64'd0, 1'b1, 16);
        req = 3'b001;
        wait_ack(1'b1);
        wait_done();
        eng_busy_mode = 1'b1;
        expect_txn(1, 64'hFFFF_0000_0000_0000, 1'b0, 18);
        req = 3'b010;
        wait_ack(1'b1);
        wait_done();

        // Reset during WAIT_DONE: no response, priority restarts at requester 0.
        exp_ack_q.push_back(3'b001);
        exp_start_q.push_back({cmd[0], len[0]});
        req = 3'b001;
        wait_ack(1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        for (int n = 0; n < 40 && spi_busy; n++) @(negedge clk);
        @(negedge clk);
        expect_txn(1, 64'hFFFF_0000_0000_0000, 1'b0, 18);
        req = 3'b010;
        wait_ack(1'b1);
        wait_done();

        check("ack_q_empty",   64'(exp_ack_q.size()),   64'd0);
        check("start_q_empty", 64'(exp_start_q.size()), 64'd0);
        check("resp_q_empty",  64'(exp_resp_q.size()),  64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one spi_controller engine among NUM_REQ requesters, e.g. the core's MMIO port, the boot flash loader and a debug port.
- Runs round-robin arbitration, latches the winning command and sequences the engine's start/busy handshake.
- Returns the masked response to the winner, tagged with its requester ID.
- Sits between the requesters and the spi_controller command/response/csr interface.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ.
- START_TIMEOUT, 15, max cycles to wait for engine busy after start before flagging an error (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  request per requester; held high until its ack.
- req_command  in  NUM_REQ*64  packed commands; requester i at [64*i+63:64*i]; byte 0 transmitted from bit 63.
- req_len  in  NUM_REQ*3  packed command lengths; byte count = len+1.
- ack  out  NUM_REQ  one-hot, one-cycle pulse when the request is accepted.
- resp_valid  out  1  one-cycle response pulse.
- resp_id  out  ID_W  requester owning the response.
- resp_data  out  64  response, masked.
- resp_err  out  1  engine start timeout; valid with resp_valid.
- spi_command  out  64  to engine command.
- spi_len  out  3  to engine CL2..CL0.
- spi_start  out  1  to engine RDY.
- spi_busy  in  1  engine BSY, active-high.
- spi_response  in  64  engine response.

Behaviour:
- Reset (synchronous): state=IDLE. All outputs 0: ack, resp_valid, resp_id, resp_data, resp_err, spi_command, spi_len, spi_start. Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority. Timeout counter 0.
- Reset is honoured in any state, including mid-transfer. spi_start drops immediately. The engine finishes its own transfer; the arbiter ignores the result.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, RESPOND.
- IDLE:
  - If req != 0, grant the first set bit searching last+1, last+2, … modulo NUM_REQ.
  - At that edge: latch the winner's command to spi_command, its len to spi_len, its ID to cur_id; set last=winner; assert ack[winner] for exactly the next cycle; go to START.
  - If req == 0, stay in IDLE.
- START: spi_start=1 for this one cycle only; clear timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - If spi_busy=1, go to WAIT_DONE.
  - Else increment the counter. When it reaches START_TIMEOUT, set the err flag and go to RESPOND.
- WAIT_DONE: stay while spi_busy=1. On the first cycle with spi_busy=0, capture spi_response into resp_data with masking, then go to RESPOND.
- Masking: keep bits [63 : 56-8*len]; zero all lower bits. len=7 keeps all 64 bits.
- RESPOND: resp_valid=1 for one cycle, resp_id=cur_id, resp_err=err. On timeout, resp_data=0. Then go to IDLE and clear err.
- resp_data, resp_id and resp_err hold their values after resp_valid drops, until the next RESPOND.
- spi_command and spi_len stay stable from START until the next grant.
- Requests arriving outside IDLE are only evaluated on return to IDLE.
- Minimum IDLE-to-IDLE cycle: IDLE, START, WAIT_BUSY, WAIT_DONE, RESPOND.
- Requester protocol:
  - Dropping req before ack is allowed; that requester is simply not granted.
  - req_command/req_len must be stable while req=1.
  - A requester may reassert req in the cycle after ack.
- No requester starves: with all requesters asserting, grants rotate 0,1,…,NUM_REQ-1,0.

Test Plan:
- Single request: req=001, cmd0=0xA5000000_00000000, len0=0; engine model busy for 16 cycles, returns 0x3C123456_789ABCDE -> ack=001 one cycle; spi_start one cycle with spi_command=0xA5000000_00000000, spi_len=0; resp_valid with resp_id=0, resp_data=0x3C000000_00000000, resp_err=0.
- Round-robin: req=111 held continuously, each requester reasserting after its ack -> ack sequence 001,010,100,001; resp_id sequence 0,1,2,0; exactly one spi_start per grant.
- Fairness after skip: last=0, req=101 -> grant 2 before 0; then req=001 -> grant 0.
- Masking: len=3, engine returns 0xFFFFFFFF_FFFFFFFF -> resp_data=0xFFFFFFFF_00000000; len=7 -> 0xFFFFFFFF_FFFFFFFF.
- Timeout: engine model never asserts busy, START_TIMEOUT=15 -> resp_valid 16 cycles after spi_start with resp_err=1, resp_data=0; FSM back in IDLE and the next request serviced normally.
- Reset mid-transfer: assert rst during WAIT_DONE -> next cycle all outputs 0, no resp_valid; after rst release with req=010, requester 1 is granted first because priority restarts at requester 0 and requester 0 is idle.
